// File: rtl/debounced_input_pio.sv
// Purpose: Avalon-MM input PIO; per-bit sync, debounce, optional invert, edge capture, masked level irq.
// Latency: pin to stable SYNC_STAGES-1+DEBOUNCE_CYCLES cycles; edge_cap +1; irq +1; readdata 1 cycle after read.
// Backpressure: none; the slave never waits, writes complete in one cycle and reads return on the next edge.
module debounced_input_pio #(
  parameter int               WIDTH           = 18,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] pins_export,
  input  logic [1:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd2;
  localparam logic [1:0] ADDR_SEL  = 2'd3;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_sel;
  logic [WIDTH-1:0] r_edge_cap;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_capture;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  // Inversion sits after the synchroniser so active-low keys read as 1 when pressed.
  assign w_s = r_sync[SYNC_STAGES-1] ^ INVERT_MASK;

  // Edges are taken from the registered debounced level against its one-cycle-old copy.
  assign w_rise    = r_stable & ~r_stable_d;
  assign w_fall    = ~r_stable & r_stable_d;
  assign w_capture = (~r_edge_sel & w_rise) | (r_edge_sel & w_fall);

  assign w_wr    = avs_chipselect & avs_write;
  assign w_rd    = avs_chipselect & avs_read;
  assign w_wdata = avs_writedata[WIDTH-1:0];
  assign w_clr   = (w_wr && avs_address == ADDR_CAP) ? w_wdata : '0;

  // Bits above WIDTH are accepted and dropped.
  assign w_unused_wdata = ^avs_writedata;

  // Synchroniser chain: stage 0 samples the raw asynchronous pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= pins_export;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Per-bit debounce: count consecutive cycles of disagreement, accept the new level on the last one.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_stable <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_s[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= w_s[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_stable_d <= '0;
    else                r_stable_d <= r_stable;
  end

  // Control registers; a new capture beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_irq_mask <= '0;
      r_edge_sel <= '0;
      r_edge_cap <= '0;
    end else begin
      if (w_wr && avs_address == ADDR_MASK) r_irq_mask <= w_wdata;
      if (w_wr && avs_address == ADDR_SEL)  r_edge_sel <= w_wdata;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_capture;
    end
  end

  // Read mux of the pre-write register values; unused upper bits read 0.
  always_comb begin
    w_rdata = '0;
    case (avs_address)
      ADDR_DATA: w_rdata[WIDTH-1:0] = r_stable;
      ADDR_MASK: w_rdata[WIDTH-1:0] = r_irq_mask;
      ADDR_CAP:  w_rdata[WIDTH-1:0] = r_edge_cap;
      ADDR_SEL:  w_rdata[WIDTH-1:0] = r_edge_sel;
      default:   w_rdata = '0;
    endcase
  end

  // Read data is latched on a read cycle and held until the next one.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)   avs_readdata <= '0;
    else if (w_rd)        avs_readdata <= w_rdata;
  end

  // Level interrupt, registered one cycle behind edge_cap and the mask.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq <= 1'b0;
    else                irq <= |(r_edge_cap & r_irq_mask);
  end

endmodule

// File: tb/tb_debounced_input_pio.sv
// Purpose: directed self-checking bench for debounced_input_pio (WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, INVERT_MASK=4'b0001).
// Latency: inputs driven and outputs sampled 1 ns after each rising clock edge.
// Backpressure: not applicable; the bench drives one Avalon cycle per clock.
module tb_debounced_input_pio;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [3:0]  pins_export = 4'b0000;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_chipselect = 1'b0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] rdv;

  debounced_input_pio #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK(4'b0001)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .pins_export(pins_export),
    .avs_address(avs_address),
    .avs_chipselect(avs_chipselect),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write = 1'b1;
    tick(1);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_chipselect = 1'b1; avs_read = 1'b1;
    tick(1);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("reset_readdata", avs_readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset_reset_n = 1'b1;

    // Idle after reset: inverted bit 0 debounces to 1 and captures a rise
    tick(20);
    rd(2'd0, rdv); chk("idle_data", rdv, 32'h1);
    rd(2'd2, rdv); chk("idle_cap", rdv, 32'h1);
    chk("idle_irq", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'hF);
    rd(2'd2, rdv); chk("boot_w1c_cap", rdv, 32'h0);
    chk("boot_w1c_irq", {31'b0, irq}, 32'h0);

    // 3-cycle glitch on bit 2 is filtered
    pins_export = 4'b0100;
    tick(3);
    pins_export = 4'b0000;
    tick(10);
    rd(2'd0, rdv); chk("glitch_data", rdv, 32'h1);
    rd(2'd2, rdv); chk("glitch_cap", rdv, 32'h0);

    // Masked rising edge on bit 2 with exact latency
    wr(2'd1, 32'h4);
    pins_export = 4'b0100;
    tick(1);                       // first sampling edge k
    avs_address = 2'd0; avs_chipselect = 1'b1; avs_read = 1'b1;
    tick(5);                       // read at k+5 sees stable before the update
    chk("rise_data_k5", avs_readdata, 32'h1);
    tick(1);                       // k+6: stable[2] visible, edge_cap sets
    chk("rise_data_k6", avs_readdata, 32'h5);
    chk("rise_irq_k6", {31'b0, irq}, 32'h0);
    tick(1);                       // k+7: irq asserts
    chk("rise_irq_k7", {31'b0, irq}, 32'h1);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    rd(2'd2, rdv); chk("rise_cap", rdv, 32'h4);
    wr(2'd2, 32'h4);               // W1C at edge m
    chk("w1c_irq_m", {31'b0, irq}, 32'h1);
    tick(1);
    chk("w1c_irq_m1", {31'b0, irq}, 32'h0);

    // Falling bit 2 is ignored with rising selection
    pins_export = 4'b0000;
    tick(10);
    rd(2'd2, rdv); chk("fall2_cap", rdv, 32'h0);
    chk("fall2_irq", {31'b0, irq}, 32'h0);

    // Falling-edge selection on bit 3
    wr(2'd3, 32'h8);
    pins_export = 4'b1000;
    tick(10);
    rd(2'd2, rdv); chk("sel_rise_cap", rdv, 32'h0);
    rd(2'd0, rdv); chk("sel_rise_data", rdv, 32'h9);
    pins_export = 4'b0000;
    tick(10);
    rd(2'd2, rdv); chk("sel_fall_cap", rdv, 32'h8);
    rd(2'd0, rdv); chk("sel_fall_data", rdv, 32'h1);
    chk("sel_fall_irq", {31'b0, irq}, 32'h0);
    rd(2'd3, rdv); chk("sel_readback", rdv, 32'h8);
    wr(2'd2, 32'h8);

    // W1C of bit 1 in the same cycle its capture sets: set wins
    wr(2'd1, 32'h2);
    pins_export = 4'b0010;
    tick(1);                       // k
    tick(5);                       // k+5: stable[1] set
    avs_address = 2'd2; avs_writedata = 32'h2; avs_chipselect = 1'b1; avs_write = 1'b1;
    tick(1);                       // k+6: capture and clear together
    avs_chipselect = 1'b0; avs_write = 1'b0;
    rd(2'd2, rdv); chk("setwins_cap", rdv, 32'h2);
    chk("setwins_irq", {31'b0, irq}, 32'h1);

    // Read and write in the same cycle return the pre-write value
    avs_address = 2'd1; avs_writedata = 32'h5;
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
    tick(1);
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    chk("rw_pre_value", avs_readdata, 32'h2);
    rd(2'd1, rdv); chk("rw_new_mask", rdv, 32'h5);
    chk("rw_irq_unmasked", {31'b0, irq}, 32'h0);

    // Upper bits ignored; DATA not writable
    wr(2'd1, 32'hFFFF_FFF2);
    rd(2'd1, rdv); chk("mask_upper_bits", rdv, 32'h2);
    chk("mask_irq_back", {31'b0, irq}, 32'h1);
    wr(2'd0, 32'hF);
    rd(2'd0, rdv); chk("data_readonly", rdv, 32'h3);

    // Reset mid-debounce with a pending masked edge
    pins_export = 4'b0100;
    tick(2);
    reset_reset_n = 1'b0;
    #1;
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_readdata", avs_readdata, 32'h0);
    tick(2);
    reset_reset_n = 1'b1;          // released just after edge R
    rd(2'd1, rdv); chk("arst_mask", rdv, 32'h0);    // R+1
    rd(2'd3, rdv); chk("arst_sel", rdv, 32'h0);     // R+2
    rd(2'd2, rdv); chk("arst_cap", rdv, 32'h0);     // R+3
    chk("arst_irq_after", {31'b0, irq}, 32'h0);
    tick(2);                                        // R+4, R+5
    rd(2'd0, rdv); chk("resettle_r6", rdv, 32'h1);  // R+6 sees stable before bit 2 lands
    rd(2'd0, rdv); chk("resettle_r7", rdv, 32'h5);  // R+7

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/debounced_input_pio.md
# debounced_input_pio

Parametrised Avalon-MM input PIO that supersedes the fixed keys, switches and joystick input ports on the Nios II system. Each channel passes through a synchroniser and a per-bit debounce filter, with optional per-bit inversion. Debounced edges are captured per bit as rising or falling, and a masked interrupt is raised to the Nios II. One instance serves any board input group: 4 keys, 18 switches, or a 5-bit joystick.

## Interface
Parameters:
- WIDTH, 18: number of input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a new level, minimum 1. 50000 is 1 ms at 50 MHz.
- INVERT_MASK, 0: bit i = 1 inverts channel i after sync. Use it for active-low keys.

Ports:
- clk_clk, input, 1: system clock. The single clock domain.
- reset_reset_n, input, 1: asynchronous, active-low reset.
- pins_export, input, WIDTH: raw, asynchronous board inputs.
- avs_address, input, 2: register select.
- avs_chipselect, input, 1: slave select.
- avs_read, input, 1: read strobe.
- avs_write, input, 1: write strobe.
- avs_writedata, input, 32: write data.
- avs_readdata, output, 32: read data, registered.
- irq, output, 1: level interrupt, registered.

## Operation
- Data path per bit i: SYNC_STAGES flops, then XOR with INVERT_MASK[i] to give s[i], then the debounce filter, then stable[i].
- Debounce counter: width = clog2(DEBOUNCE_CYCLES+1), one per bit.
  - If s[i] == stable[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, stable[i] <= s[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge detect: rise[i] = stable rising 0 to 1; fall[i] = stable falling 1 to 0. Both are evaluated on the registered stable value against its previous value.
- Capture: edge_cap[i] sets when (edge_sel[i] == 0 and rise[i]) or (edge_sel[i] == 1 and fall[i]).
- Register map (word addresses). Unused upper bits read 0 and ignore writes.
  - 0 DATA: read-only, returns stable. Writes are ignored.
  - 1 IRQ_MASK: read/write, WIDTH bits.
  - 2 EDGE_CAP: read; write-1-to-clear per bit.
  - 3 EDGE_SEL: read/write; bit = 0 selects rising, 1 selects falling.
- irq <= |(edge_cap & irq_mask).
- A write cycle is chipselect & write. A read cycle is chipselect & read. Read and write asserted in the same cycle: the write takes effect and readdata returns the pre-write value.
- Simultaneous W1C and a new capture on the same bit: set wins, bit stays 1.
- Writing IRQ_MASK does not alter EDGE_CAP. Changing EDGE_SEL affects only future edges.
- Reset values:
  - Sync flops, stable, counters, edge_cap, irq_mask, edge_sel: all 0.
  - avs_readdata = 0, irq = 0.
  - After reset, stable reaches an inverted channel's idle 1 through the normal debounce path. That transition captures a rising edge only if edge_sel selects rising. Software clears EDGE_CAP after boot.
- Reset asserted mid-debounce or mid-transaction clears all state immediately. There is no pending edge, and irq is low.

## Timing
- Read latency: 1 cycle. avs_readdata is valid on the edge after the read cycle and holds until the next read. There are no wait states, and writes complete in 1 cycle.
- A pin change sampled at edge k appears on s at edge k+SYNC_STAGES−1.
- stable updates at edge k+SYNC_STAGES−1+DEBOUNCE_CYCLES.
- edge_cap sets 1 cycle after stable; irq asserts 1 cycle after edge_cap.
- W1C at edge m: edge_cap is cleared at m, and irq deasserts at m+1 if no other masked bit is set.
- Mask write at edge m: irq reflects the new mask at m+1.
- Counter wrap is impossible: the counter saturates by clearing at DEBOUNCE_CYCLES.

## Test plan
Bench settings: WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, INVERT_MASK=4'b0001.
- Reset, release, idle 20 cycles -> DATA reads 4'b0001 and EDGE_CAP reads 4'b0001 (rising on bit 0). After W1C 0xF, EDGE_CAP reads 0 and irq stays 0.
- Bit 2 pulses high for 3 cycles -> stable and DATA unchanged, EDGE_CAP = 0. Bit 2 held high for 10 cycles -> DATA bit 2 = 1 exactly 5 cycles after the first sampling edge.
- IRQ_MASK = 4'b0100, rising edge on bit 2 -> EDGE_CAP = 4'b0100 and irq = 1. Write EDGE_CAP = 4'b0100 -> irq = 0 the next cycle.
- EDGE_SEL = 4'b1000, bit 3 goes 0 to 1 and back to 0 (each held for 10 cycles) -> capture occurs only on the fall. Rising on bit 3 leaves edge_cap[3] = 0.
- W1C of bit 1 in the same cycle that edge_cap[1] sets -> bit reads 1 afterwards and irq stays asserted when masked.
- reset_reset_n pulsed low mid-debounce with a pending masked edge -> irq, readdata and all registers read 0 immediately. DATA re-settles after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
